// File: rtl/vrt_pkg.sv
// vrt_pkg: shared state encoding, register map and defaults
// for the accelerator runtime measurement controller.
package vrt_pkg;

  localparam int unsigned NrEventsDef = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StRun   = 2'd2,
    StDrain = 2'd3
  } vrt_state_e;

  localparam logic [2:0] AddrRuntime = 3'd0;
  localparam logic [2:0] AddrEvt0    = 3'd1;
  localparam logic [2:0] AddrEvt1    = 3'd2;
  localparam logic [2:0] AddrEvt2    = 3'd3;
  localparam logic [2:0] AddrStatus  = 3'd4;

endpackage

// File: rtl/vrt_sat_counter.sv
// vrt_sat_counter: saturating counter with a snapshot buffer.
// The snapshot captures the value including this cycle's increment.
module vrt_sat_counter
  import vrt_pkg::*;
#(
  parameter int unsigned CntWidth = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr,
  input  logic                inc,
  input  logic                snap,
  output logic [CntWidth-1:0] cnt_o,
  output logic [CntWidth-1:0] buf_o
);

  localparam logic [CntWidth-1:0] One = CntWidth'(1);

  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] r_buf;
  logic [CntWidth-1:0] w_next;

  always_comb begin
    w_next = r_cnt;
    if (inc && (r_cnt != '1)) begin
      w_next = r_cnt + One;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_buf <= '0;
    end else if (clr) begin
      r_cnt <= '0;
      r_buf <= '0;
    end else begin
      r_cnt <= w_next;
      if (snap) begin
        r_buf <= w_next;
      end
    end
  end

  assign cnt_o = r_cnt;
  assign buf_o = r_buf;

endmodule

// File: rtl/vrt_measure_ctrl.sv
// vrt_measure_ctrl: arm/run/drain window timing vector work.
// Event counters exist only when VRT_EVENT_CNT_EN is defined.
module vrt_measure_ctrl
  import vrt_pkg::*;
#(
  parameter int unsigned CntWidth = 64,
  parameter int unsigned NrEvents = NrEventsDef
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sw_arm_i,
  input  logic                sw_stop_i,
  input  logic                acc_req_valid_i,
  input  logic                ara_idle_i,
  input  logic [NrEvents-1:0] event_i,
  input  logic                rd_req_i,
  input  logic [2:0]          rd_addr_i,
  output logic                rd_valid_o,
  output logic [CntWidth-1:0] rd_data_o,
  output logic                busy_o,
  output logic                done_o
);

  vrt_state_e          r_state;
  logic                r_pending;
  logic                r_busy;
  logic                r_done;
  logic                r_rd_valid;
  logic [CntWidth-1:0] r_rd_data;

  logic                w_run;
  logic                w_drain;
  logic                w_snap;
  logic                w_clr;
  logic [CntWidth-1:0] w_rt_buf;
  logic [CntWidth-1:0] w_rt_cnt_unused;
  logic [CntWidth-1:0] w_status;
  logic [CntWidth-1:0] w_rd_mux;
  logic [CntWidth-1:0] w_ev_rd [3];

  assign w_run   = (r_state == StRun) || (r_state == StDrain);
  assign w_drain = ara_idle_i && !acc_req_valid_i;
  assign w_clr   = (r_state == StIdle) && sw_arm_i;
  // In RUN a snapshot needs outstanding work or a coinciding stop.
  assign w_snap  = w_run && w_drain &&
                   (r_pending || sw_stop_i || (r_state == StDrain));

  vrt_sat_counter #(.CntWidth(CntWidth)) u_rt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (w_clr),
    .inc   (w_run),
    .snap  (w_snap),
    .cnt_o (w_rt_cnt_unused),
    .buf_o (w_rt_buf)
  );

`ifdef VRT_EVENT_CNT_EN
  logic [CntWidth-1:0] w_ev_buf        [NrEvents];
  logic [CntWidth-1:0] w_ev_cnt_unused [NrEvents];

  for (genvar g = 0; g < NrEvents; g++) begin : g_ev
    vrt_sat_counter #(.CntWidth(CntWidth)) u_ev (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (w_clr),
      .inc   (w_run && event_i[g]),
      .snap  (w_snap),
      .cnt_o (w_ev_cnt_unused[g]),
      .buf_o (w_ev_buf[g])
    );
  end

  for (genvar g = 0; g < 3; g++) begin : g_ev_rd
    if (g < NrEvents) begin : g_on
      assign w_ev_rd[g] = w_ev_buf[g];
    end else begin : g_off
      assign w_ev_rd[g] = '0;
    end
  end
`else
  logic w_ev_unused;
  assign w_ev_unused = ^event_i;
  assign w_ev_rd[0]  = '0;
  assign w_ev_rd[1]  = '0;
  assign w_ev_rd[2]  = '0;
`endif

  assign w_status = CntWidth'({r_state, r_pending});

  always_comb begin
    w_rd_mux = '0;
    unique case (rd_addr_i)
      AddrRuntime: w_rd_mux = w_rt_buf;
      AddrEvt0:    w_rd_mux = w_ev_rd[0];
      AddrEvt1:    w_rd_mux = w_ev_rd[1];
      AddrEvt2:    w_rd_mux = w_ev_rd[2];
      AddrStatus:  w_rd_mux = w_status;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (sw_arm_i) begin
            r_state   <= StArmed;
            r_pending <= 1'b0;
          end
        end
        StArmed: begin
          if (sw_stop_i) begin
            r_state <= StIdle;
          end else if (acc_req_valid_i) begin
            r_state   <= StRun;
            r_pending <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        StRun: begin
          if (acc_req_valid_i) begin
            r_pending <= 1'b1;
          end else if (w_snap) begin
            r_pending <= 1'b0;
          end
          if (sw_stop_i && w_drain) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (sw_stop_i) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (acc_req_valid_i) begin
            r_pending <= 1'b1;
          end else if (w_drain) begin
            r_pending <= 1'b0;
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_req_i;
      r_rd_data  <= rd_req_i ? w_rd_mux : '0;
    end
  end

  assign rd_valid_o = r_rd_valid;
  assign rd_data_o  = r_rd_data;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule
